alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
// - Multi-cycle control sequencer on the driving side of the ALU. Issues Aluopt/Shamp to the ALU and reads its Z/N flags back.
// - Accepts one 32-bit LEGv8 instruction per handshake, decodes it and sequences EXEC over several cycles.
// - Resolves CBZ/CBNZ/B.cond from the returned flags and emits datapath control plus a branch decision.
// PARAMETERS
// - OPW    4   width of the Aluopt output, fixed to the ALU encoding
// - SHW    6   width of the Shamp output
// PORTS
// - clk          in   1   single clock, rising edge
// - reset        in   1   synchronous, active-high
// - InstrValid   in   1   instruction present
// - InstrReady   out  1   sequencer can accept (high only in IDLE)
// - Instr        in   32  LEGv8 instruction word
// - Aluopt       out  4   ALU op: 0 ADD,1 SUB,2 AND,3 ORR,4 NAND,5 EOR,6 LSL,7 LSR,8 PASS-B
// - Shamp        out  6   shift amount, Instr[15:10]
// - AluSrcImm    out  1   ALU B operand = immediate
// - Z            in   1   ALU flag; after PASS-B: 1 = B nonzero
// - N            in   2   ALU flags; after SUB: N[0] = (A-B >= 0), N[1] = (A-B != 0)
// - RegWrite, MemRead, MemWrite, MemToReg   out 1 each   datapath strobes, valid while DoneValid
// - BranchTaken  out  1   branch decision, valid while DoneValid
// - Illegal      out  1   undecoded opcode seen
// - DoneValid    out  1   result/control valid
// - DoneReady    in   1   consumer accepts result
// BEHAVIOUR
// - Reset: state IDLE; every output 0 except InstrReady = 1; Aluopt = 0; flag register {Nq, Zq} = 0.
// - Reset wins over all events, including mid-sequence; an in-flight instruction is dropped.
// - FSM: IDLE -> DECODE -> EXEC -> RESOLVE -> DONE -> IDLE.
//   - IDLE: on InstrValid & InstrReady, latch Instr.
//   - DECODE: 1 cycle; select op and strobes.
//   - EXEC: 1 cycle; Aluopt/Shamp/AluSrcImm driven; end of cycle samples flags.
//   - RESOLVE: 1 cycle; compute BranchTaken.
//   - DONE: hold every output stable while DoneValid=1 and DoneReady=0; leave on DoneReady.
// - Latency: DoneValid asserts 4 cycles after acceptance; min throughput 1 instruction per 5 cycles.
// - Aluopt holds its EXEC value through RESOLVE and DONE; returns to 0 in IDLE.
// - Decode (Instr[31:21] unless noted):
//   - 10001011000 ADD / 11001011000 SUB / 10001010000 AND / 10101010000 ORR / 11001010000 EOR -> op 0/1/2/3/5, RegWrite.
//   - 11010011011 LSL / 11010011010 LSR -> op 6/7, RegWrite.
//   - [31:22] 1001000100 ADDI / 1101000100 SUBI -> op 0/1, AluSrcImm, RegWrite.
//   - 11111000010 LDUR -> op 0, AluSrcImm, MemRead, MemToReg, RegWrite.
//   - 11111000000 STUR -> op 0, AluSrcImm, MemWrite.
//   - [31:24] 10110100 CBZ / 10110101 CBNZ -> op 8.
//   - [31:24] 01010100 B.cond -> op 8, no ALU use; [31:26] 000101 B -> BranchTaken=1.
// - Flag register: Nq updates only at end of EXEC of SUB/SUBI; Zq updates only at end of EXEC of op 8.
// - CBZ taken iff sampled Z == 0; CBNZ taken iff Z == 1.
// - B.cond uses Nq from the most recent SUB/SUBI; cond = Instr[3:0]:
//   - 0 EQ: !Nq[1];  1 NE: Nq[1];  A GE: Nq[0];  B LT: !Nq[0].
//   - C GT: Nq[0] & Nq[1];  D LE: !Nq[0] | !Nq[1];  E AL: 1.
//   - Other cond codes: not taken.
// - BranchTaken is 0 for all non-branch instructions.
// - Simultaneous InstrValid outside IDLE: ignored, InstrReady = 0.
// - DONE -> IDLE transition and the next acceptance cannot occur in the same cycle.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined:
//   - Undecoded opcode goes DECODE -> TRAP; Illegal = 1 and InstrReady = 0, both sticky until reset.
//   - No DoneValid is issued for that instruction.
// - ILLEGAL_TRAP_EN undefined:
//   - Undecoded opcode runs as a NOP through the full FSM with all strobes 0 and Aluopt = 0.
//   - Illegal pulses 1 alongside DoneValid only.
// TESTING
// - Instr=0x8B030041 (ADD X1,X2,X3) -> Aluopt=0 in EXEC, RegWrite=1, DoneValid 4 cycles after handshake.
// - SUB with N=2'b01, then B.EQ Instr=0x54000000 -> BranchTaken=1; repeat with N=2'b11 -> BranchTaken=0.
// - CBZ Instr=0xB4000005 with Z=0 in EXEC -> Aluopt=8, BranchTaken=1; with Z=1 -> BranchTaken=0.
// - LSL with Instr[15:10]=6'd13 -> Aluopt=6, Shamp=13 through EXEC..DONE.
// - Hold DoneReady=0 for 3 cycles -> all outputs stable, InstrReady=0; raise DoneReady -> IDLE next cycle.
// - Reset in EXEC -> next cycle InstrReady=1, Aluopt=0, DoneValid=0, and the flag register cleared.
// - Instr=0xFFFFFFFF: with ILLEGAL_TRAP_EN -> Illegal=1 held, InstrReady=0; without it -> NOP with an Illegal pulse.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Multi-cycle issue sequencer on the driving side of the ALU. Accepts one
// LEGv8 instruction word per handshake, decodes it, presents Aluopt/Shamp/
// AluSrcImm for one EXEC cycle, samples the returned Z/N flags and resolves
// CBZ/CBNZ/B.cond/B before presenting datapath strobes under DoneValid.
//
// Build option: ILLEGAL_TRAP_EN
//   defined   - an undecoded opcode locks the sequencer in TRAP with a sticky
//               Illegal and InstrReady low until reset; no DoneValid for it.
//   undefined - an undecoded opcode runs as a NOP through the full sequence and
//               Illegal pulses alongside its DoneValid.
//
// state   | meaning
// IDLE    | InstrReady=1, waiting for an instruction
// DECODE  | latched word decoded into op, strobes and branch kind
// EXEC    | Aluopt/Shamp/AluSrcImm presented; flags sampled at end of cycle
// RESOLVE | branch decision formed from the flag register
// DONE    | DoneValid=1, every output frozen until DoneReady
// TRAP    | sticky Illegal, nothing accepted until reset

module alu_issue_ctrl #(
   parameter int OPW = 4,
   parameter int SHW = 6
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           InstrValid,
   output logic           InstrReady,
   input  logic [31:0]    Instr,
   output logic [OPW-1:0] Aluopt,
   output logic [SHW-1:0] Shamp,
   output logic           AluSrcImm,
   input  logic           Z,
   input  logic [1:0]     N,
   output logic           RegWrite,
   output logic           MemRead,
   output logic           MemWrite,
   output logic           MemToReg,
   output logic           BranchTaken,
   output logic           Illegal,
   output logic           DoneValid,
   input  logic           DoneReady
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_RESOLVE,
      S_DONE,
      S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      BR_NONE,
      BR_CBZ,
      BR_CBNZ,
      BR_COND,
      BR_UNC
   } br_t;

   localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
   localparam logic [OPW-1:0] OP_AND   = OPW'(2);
   localparam logic [OPW-1:0] OP_ORR   = OPW'(3);
   localparam logic [OPW-1:0] OP_EOR   = OPW'(5);
   localparam logic [OPW-1:0] OP_LSL   = OPW'(6);
   localparam logic [OPW-1:0] OP_LSR   = OPW'(7);
   localparam logic [OPW-1:0] OP_PASSB = OPW'(8);

   state_t      state;

   // Only the instruction fields the sequencer actually consumes are kept.
   logic [10:0] opc_q;
   logic [5:0]  sh_q;
   logic [3:0]  cond_q;

   // Decoded controls parked between DECODE and RESOLVE.
   br_t         br_q;
   logic        rw_q;
   logic        mr_q;
   logic        mw_q;
   logic        m2r_q;
   logic        ill_q;

   // Flag register: Nq from the latest SUB/SUBI, Zq from the latest PASS-B.
   logic [1:0]  Nq;
   logic        Zq;

   // Combinational decode of the latched opcode.
   logic [OPW-1:0] d_op;
   logic           d_imm;
   logic           d_rw;
   logic           d_mr;
   logic           d_mw;
   logic           d_m2r;
   logic           d_ill;
   br_t            d_br;

   logic           trap_now;
   logic           branch_now;

   // B.cond evaluation; Nq[0] = (A-B >= 0), Nq[1] = (A-B != 0).
   function automatic logic cond_taken(input logic [3:0] cond, input logic [1:0] nq);
      logic t;
      case (cond)
         4'h0:    t = !nq[1];
         4'h1:    t = nq[1];
         4'hA:    t = nq[0];
         4'hB:    t = !nq[0];
         4'hC:    t = nq[0] & nq[1];
         4'hD:    t = !nq[0] | !nq[1];
         4'hE:    t = 1'b1;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Opcode decode: ALU op, operand select, datapath strobes and branch kind.
   always_comb begin
      d_op  = OP_ADD;
      d_imm = 1'b0;
      d_rw  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_m2r = 1'b0;
      d_ill = 1'b0;
      d_br  = BR_NONE;
      casez (opc_q)
         11'b10001011000: begin d_op = OP_ADD; d_rw = 1'b1; end
         11'b11001011000: begin d_op = OP_SUB; d_rw = 1'b1; end
         11'b10001010000: begin d_op = OP_AND; d_rw = 1'b1; end
         11'b10101010000: begin d_op = OP_ORR; d_rw = 1'b1; end
         11'b11001010000: begin d_op = OP_EOR; d_rw = 1'b1; end
         11'b11010011011: begin d_op = OP_LSL; d_rw = 1'b1; end
         11'b11010011010: begin d_op = OP_LSR; d_rw = 1'b1; end
         11'b1001000100?: begin d_op = OP_ADD; d_imm = 1'b1; d_rw = 1'b1; end
         11'b1101000100?: begin d_op = OP_SUB; d_imm = 1'b1; d_rw = 1'b1; end
         11'b11111000010: begin
            d_op  = OP_ADD;
            d_imm = 1'b1;
            d_mr  = 1'b1;
            d_m2r = 1'b1;
            d_rw  = 1'b1;
         end
         11'b11111000000: begin d_op = OP_ADD; d_imm = 1'b1; d_mw = 1'b1; end
         11'b10110100???: begin d_op = OP_PASSB; d_br = BR_CBZ; end
         11'b10110101???: begin d_op = OP_PASSB; d_br = BR_CBNZ; end
         11'b01010100???: begin d_op = OP_PASSB; d_br = BR_COND; end
         // Unconditional B needs no ALU result; op stays at ADD.
         11'b000101?????: begin d_op = OP_ADD; d_br = BR_UNC; end
         default:         d_ill = 1'b1;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   assign trap_now = d_ill;
`else
   assign trap_now = 1'b0;
`endif

   // Branch decision from the flag register as it stands in RESOLVE.
   always_comb begin
      branch_now = 1'b0;
      case (br_q)
         BR_CBZ:  branch_now = !Zq;
         BR_CBNZ: branch_now = Zq;
         BR_COND: branch_now = cond_taken(cond_q, Nq);
         BR_UNC:  branch_now = 1'b1;
         default: branch_now = 1'b0;
      endcase
   end

   // Sequencer FSM with registered outputs and the flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         InstrReady  <= 1'b1;
         Aluopt      <= '0;
         Shamp       <= '0;
         AluSrcImm   <= 1'b0;
         RegWrite    <= 1'b0;
         MemRead     <= 1'b0;
         MemWrite    <= 1'b0;
         MemToReg    <= 1'b0;
         BranchTaken <= 1'b0;
         Illegal     <= 1'b0;
         DoneValid   <= 1'b0;
         opc_q       <= '0;
         sh_q        <= '0;
         cond_q      <= '0;
         br_q        <= BR_NONE;
         rw_q        <= 1'b0;
         mr_q        <= 1'b0;
         mw_q        <= 1'b0;
         m2r_q       <= 1'b0;
         ill_q       <= 1'b0;
         Nq          <= '0;
         Zq          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (InstrValid && InstrReady) begin
                  opc_q      <= Instr[31:21];
                  sh_q       <= Instr[15:10];
                  cond_q     <= Instr[3:0];
                  InstrReady <= 1'b0;
                  state      <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (trap_now) begin
                  Illegal <= 1'b1;
                  state   <= S_TRAP;
               end else begin
                  Aluopt    <= d_op;
                  // An undecoded word behaves as a NOP, so no shift amount either.
                  Shamp     <= d_ill ? '0 : SHW'(sh_q);
                  AluSrcImm <= d_imm;
                  rw_q      <= d_rw;
                  mr_q      <= d_mr;
                  mw_q      <= d_mw;
                  m2r_q     <= d_m2r;
                  ill_q     <= d_ill;
                  br_q      <= d_br;
                  state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (Aluopt == OP_SUB) begin
                  Nq <= N;
               end
               if (Aluopt == OP_PASSB) begin
                  Zq <= Z;
               end
               state <= S_RESOLVE;
            end
            S_RESOLVE: begin
               BranchTaken <= branch_now;
               RegWrite    <= rw_q;
               MemRead     <= mr_q;
               MemWrite    <= mw_q;
               MemToReg    <= m2r_q;
               Illegal     <= ill_q;
               DoneValid   <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: begin
               // InstrReady rises only after this edge, so acceptance waits a cycle.
               if (DoneReady) begin
                  Aluopt      <= '0;
                  Shamp       <= '0;
                  AluSrcImm   <= 1'b0;
                  RegWrite    <= 1'b0;
                  MemRead     <= 1'b0;
                  MemWrite    <= 1'b0;
                  MemToReg    <= 1'b0;
                  BranchTaken <= 1'b0;
                  Illegal     <= 1'b0;
                  DoneValid   <= 1'b0;
                  InstrReady  <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_TRAP: begin
               Illegal    <= 1'b1;
               InstrReady <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
